// File: rtl/sync_fifo_pkg.sv
// Shared sizing constants for the 32x32 single-clock FIFO.
// CNT_W is one bit wider than the pointers so the count can hold the value DEPTH.
package sync_fifo_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = ADDR_W + 1;

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem_32x32.sv
// Simple dual-port storage: synchronous write plus a registered, enable-gated read.
// Only the read register is reset; the array keeps its contents across reset.
module fifo_mem_32x32
    import sync_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // The read word is held whenever no read is accepted.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : fifo_mem_32x32

// File: rtl/sync_fifo_w32_d32.sv
// Single-clock FIFO, 32 words of 32 bits, with registered read data and flags.
// Pointers, occupancy count and full/empty flags live here; storage is in fifo_mem_32x32.
module sync_fifo_w32_d32
    import sync_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_fifo_empty,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_fifo_full
);

    logic              wr_en;
    logic              rd_en;

    logic [ADDR_W-1:0] wr_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  count_q;
    logic              full_d;
    logic              full_q;
    logic              empty_d;
    logic              empty_q;

    // Accepts are qualified by the registered flags, so a write while full
    // and a read while empty are dropped without touching any state.
    assign wr_en = i_wr & ~full_q;
    assign rd_en = i_rd & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    fifo_mem_32x32 u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (i_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (o_data)
    );

    assign o_fifo_full  = full_q;
    assign o_fifo_empty = empty_q;

endmodule : sync_fifo_w32_d32

// File: tb/tb_sync_fifo_w32_d32.sv
// Directed bench for sync_fifo_w32_d32 with hand-computed expected words and flags.
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
module tb_sync_fifo_w32_d32;

    logic        clk;
    logic        rst_n;
    logic        i_wr;
    logic [31:0] i_data;
    logic        o_fifo_empty;
    logic        i_rd;
    logic [31:0] o_data;
    logic        o_fifo_full;

    int n_vec;
    int n_miss;

    sync_fifo_w32_d32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr         (i_wr),
        .i_data       (i_data),
        .o_fifo_empty (o_fifo_empty),
        .i_rd         (i_rd),
        .o_data       (o_data),
        .o_fifo_full  (o_fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] d);
        i_wr   = 1'b1;
        i_data = d;
        step();
        i_wr   = 1'b0;
    endtask

    task automatic rd_word(input string tag, input logic [31:0] exp);
        i_rd = 1'b1;
        step();
        i_rd = 1'b0;
        chk(tag, o_data, exp);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        i_wr   = 1'b0;
        i_rd   = 1'b0;
        i_data = '0;

        // reset
        step();
        chk("rst_empty", 32'(o_fifo_empty), 32'd1);
        chk("rst_full",  32'(o_fifo_full),  32'd0);
        chk("rst_data",  o_data,            32'h0);
        rst_n = 1'b1;
        step();

        // basic order
        wr_word(32'h1111_1111);
        chk("basic_not_empty", 32'(o_fifo_empty), 32'd0);
        wr_word(32'h2222_2222);
        wr_word(32'h3333_3333);
        i_rd = 1'b1;
        step();
        chk("basic_rd0", o_data, 32'h1111_1111);
        step();
        chk("basic_rd1", o_data, 32'h2222_2222);
        step();
        chk("basic_rd2", o_data, 32'h3333_3333);
        chk("basic_empty", 32'(o_fifo_empty), 32'd1);
        i_rd = 1'b0;

        // fill to full, overflow, drain
        for (int i = 0; i < 32; i++) begin
            wr_word(32'(i));
            if (i == 30) chk("fill_not_full_31", 32'(o_fifo_full), 32'd0);
        end
        chk("fill_full", 32'(o_fifo_full), 32'd1);
        chk("fill_not_empty", 32'(o_fifo_empty), 32'd0);
        wr_word(32'hDEAD_BEEF);
        chk("ovf_still_full", 32'(o_fifo_full), 32'd1);
        for (int i = 0; i < 32; i++) begin
            rd_word($sformatf("drain_%0d", i), 32'(i));
            if (i == 0) chk("drain_not_full", 32'(o_fifo_full), 32'd0);
        end
        chk("drain_empty", 32'(o_fifo_empty), 32'd1);

        // underflow holds o_data (last read was 31)
        i_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("unf_data", o_data, 32'd31);
            chk("unf_empty", 32'(o_fifo_empty), 32'd1);
        end
        i_rd = 1'b0;
        wr_word(32'hCAFE_F00D);
        rd_word("unf_recover", 32'hCAFE_F00D);
        chk("unf_recover_empty", 32'(o_fifo_empty), 32'd1);

        // simultaneous read/write at occupancy 5, crossing pointer wrap
        for (int i = 0; i < 5; i++) wr_word(32'h100 + 32'(i));
        i_wr = 1'b1;
        i_rd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            i_data = 32'h200 + 32'(k);
            step();
            chk($sformatf("rw_data_%0d", k), o_data,
                (k < 5) ? (32'h100 + 32'(k)) : (32'h200 + 32'(k - 5)));
            chk("rw_full",  32'(o_fifo_full),  32'd0);
            chk("rw_empty", 32'(o_fifo_empty), 32'd0);
        end
        i_wr = 1'b0;
        i_rd = 1'b0;
        // exactly 5 entries remain: 0x223..0x227
        for (int i = 0; i < 5; i++) begin
            rd_word("rw_tail", 32'h223 + 32'(i));
        end
        chk("rw_tail_empty", 32'(o_fifo_empty), 32'd1);

        // mid-operation reset
        for (int i = 0; i < 10; i++) wr_word(32'h300 + 32'(i));
        rst_n = 1'b0;
        step();
        chk("mrst_empty", 32'(o_fifo_empty), 32'd1);
        chk("mrst_full",  32'(o_fifo_full),  32'd0);
        chk("mrst_data",  o_data,            32'h0);
        rst_n = 1'b1;
        wr_word(32'h5A5A_5A5A);
        rd_word("mrst_new", 32'h5A5A_5A5A);
        chk("mrst_new_empty", 32'(o_fifo_empty), 32'd1);
        rd_word("mrst_no_stale", 32'h5A5A_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_sync_fifo_w32_d32
